cordic_sched: RTL and testbench
===============================

CORDIC_SCHED -- requirements
Module: cordic_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one rec2pol CORDIC datapath; SHALL be 2..8.
REQ-002 Parameter NITER, default 16: CORDIC iteration cycles per conversion; SHALL be 1..63.
REQ-003 Parameter XW, default 129: signed operand width.
REQ-004 clock  in  1  single clock; all state SHALL change on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset; the port is named reset, and reset=0 SHALL reset the block.
REQ-006 flush  in  1  synchronous abort; returns to IDLE.
REQ-007 req_valid  in  NREQ  per-requester conversion request.
REQ-008 req_x  in  NREQ*XW  flattened signed X operands; requester i occupies bits [i*XW +: XW].
REQ-009 req_y  in  NREQ*XW  flattened signed Y operands, same packing.
REQ-010 req_ready  out  NREQ  one-hot grant; a request is accepted on an edge where req_valid[i] and req_ready[i] are both 1.
REQ-011 cordic_enable  out  1  drives the CORDIC enable.
REQ-012 cordic_start  out  1  drives the CORDIC start.
REQ-013 cordic_x  out  XW  registered X operand to the CORDIC.
REQ-014 cordic_y  out  XW  registered Y operand to the CORDIC.
REQ-015 cordic_angle  in  19  CORDIC angle, 9Q10 degrees.
REQ-016 res_valid  out  1  result available.
REQ-017 res_ready  in  1  consumer accepts the result.
REQ-018 res_angle  out  19  captured angle, 9Q10.
REQ-019 res_id  out  3  index of the requester that owns res_angle.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 The FSM SHALL have the states IDLE, LOAD, ITER, CAPT and RESP, and SHALL have no other states.
REQ-022 In IDLE, req_ready SHALL be one-hot on the first requester with req_valid=1, searching round-robin from pointer rr, and SHALL be all-zero when no req_valid is set.
REQ-023 req_ready SHALL be 0 in every state other than IDLE.
REQ-024 On acceptance of requester g, the block SHALL register req_x[g] into cordic_x, req_y[g] into cordic_y and g into res_id, set rr to (g+1) mod NREQ, and go to LOAD.
REQ-025 In LOAD (one cycle), cordic_start and cordic_enable SHALL both be 1, and the next state SHALL be ITER.
REQ-026 In ITER, cordic_enable SHALL be 1 and cordic_start SHALL be 0 for exactly NITER cycles, counted by an internal 6-bit counter, after which the next state SHALL be CAPT.
REQ-027 In CAPT (one cycle), cordic_enable SHALL be 0, and res_angle SHALL be loaded from cordic_angle on the exiting edge, after which the next state SHALL be RESP.
REQ-028 In RESP, res_valid SHALL be 1, and res_angle and res_id SHALL be held stable until res_ready=1.
REQ-029 A RESP cycle with res_ready=1 SHALL lead to IDLE.
REQ-030 cordic_enable SHALL be 0 in IDLE, CAPT and RESP, and cordic_start SHALL be 1 only in LOAD.
REQ-031 Latency: with an acceptance edge at cycle 0, res_valid SHALL first be 1 in cycle NITER+3, which is cycle 19 at the default parameters.
REQ-032 Throughput: a new acceptance SHALL be possible no earlier than the cycle after the res_valid/res_ready handshake, giving a minimum spacing of NITER+4 cycles.
REQ-033 Requests that are not granted SHALL wait without loss; req_valid is held by the requester until accepted.
REQ-034 Requester operands SHALL be sampled only at the acceptance edge; later changes on req_x/req_y SHALL NOT affect the conversion in progress.
REQ-035 flush=1 SHALL force IDLE on the next edge from any state, with res_valid=0, cordic_enable=0, rr unchanged, and the iteration counter cleared.
REQ-036 When flush=1 in IDLE, the block SHALL NOT accept any request in that cycle, and req_ready SHALL be forced to 0.
REQ-037 When rr points past the last active requester, the round-robin search SHALL wrap modulo NREQ.

Reset
REQ-038 reset=0 SHALL asynchronously force the following: state=IDLE, rr=0, iteration counter=0, cordic_x=0, cordic_y=0, res_angle=0, res_id=0, res_valid=0, cordic_enable=0, cordic_start=0, busy=0, req_ready=0.
REQ-039 A reset asserted mid-operation SHALL discard the conversion in progress, and no res_valid SHALL follow it.
REQ-040 The first accepting edge after reset SHALL be the first rising clock edge on which reset=1.

Verification
REQ-041 Single request: req_valid=0001, x=1000, y=1000 -> cordic_start pulses in cycle 1, cordic_enable is high in cycles 1..17, res_valid rises in cycle 19 with res_id=0 and res_angle within 2 LSB of 45.0 deg (46080).
REQ-042 Contention: req_valid=1111 held continuously, res_ready=1 -> grants in order 0,1,2,3,0, each grant spaced 20 cycles apart.
REQ-043 Back-pressure: res_ready=0 for 10 cycles in RESP -> res_valid, res_angle and res_id stay constant, req_ready stays 0000, and IDLE is reached the cycle after res_ready=1.
REQ-044 Reset mid-ITER: reset=0 in cycle 8 of ITER -> all outputs are zero immediately; after release, busy=0 and no res_valid appears.
REQ-045 Flush in CAPT: flush=1 -> IDLE on the next edge, res_valid never rises, and the next grant follows the rr pointer.
REQ-046 Negative operands: x=-1000, y=0 -> res_angle magnitude within 2 LSB of 180.0 deg (184320).

Source files
------------

// File: rtl/cordic_sched.sv
// cordic_sched: round-robin scheduler sharing one rec2pol CORDIC
// among NREQ requesters, with a valid/ready result port.
module cordic_sched #(
  parameter int NREQ  = 4,
  parameter int NITER = 16,
  parameter int XW    = 129
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*XW-1:0] req_x,
  input  logic [NREQ*XW-1:0] req_y,
  output logic [NREQ-1:0]   req_ready,
  output logic              cordic_enable,
  output logic              cordic_start,
  output logic [XW-1:0]     cordic_x,
  output logic [XW-1:0]     cordic_y,
  input  logic [18:0]       cordic_angle,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [18:0]       res_angle,
  output logic [2:0]        res_id,
  output logic              busy
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] ITER = 3'd2;
  localparam logic [2:0] CAPT = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  logic [2:0]    state;
  logic [2:0]    rr;
  logic [5:0]    cnt;
  logic [7:0]    vpad;
  logic [7:0]    gpad;
  logic [3:0]    s;
  logic [2:0]    gidx;
  logic          found;
  logic [XW-1:0] xs [8];
  logic [XW-1:0] ys [8];

  assign vpad = 8'(req_valid);
  assign gpad = 8'b1 << gidx;

  // Unpack the flattened operand buses; unused slots read as zero.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      xs[i] = '0;
      ys[i] = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      xs[i] = req_x[i*XW +: XW];
      ys[i] = req_y[i*XW +: XW];
    end
  end

  // Round-robin search starting at rr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    s     = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = {1'b0, rr} + 4'(k);
      if (s >= 4'(NREQ)) s = s - 4'(NREQ);
      if (!found && vpad[s[2:0]]) begin
        found = 1'b1;
        gidx  = s[2:0];
      end
    end
  end

  // Grant is gated by reset and flush so nothing is offered then.
  always_comb begin
    req_ready = '0;
    if (reset && !flush && state == IDLE && found)
      req_ready = gpad[NREQ-1:0];
  end

  assign cordic_start  = (state == LOAD);
  assign cordic_enable = (state == LOAD) || (state == ITER);
  assign res_valid     = (state == RESP);
  assign busy          = (state != IDLE);

  // Scheduler FSM, operand registers and result capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr        <= '0;
      cnt       <= '0;
      cordic_x  <= '0;
      cordic_y  <= '0;
      res_angle <= '0;
      res_id    <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            state    <= LOAD;
            cordic_x <= xs[gidx];
            cordic_y <= ys[gidx];
            res_id   <= gidx;
            rr       <= (gidx == 3'(NREQ-1)) ? 3'd0 : gidx + 3'd1;
          end
        end
        LOAD: begin
          state <= ITER;
          cnt   <= '0;
        end
        ITER: begin
          if (cnt == 6'(NITER-1)) begin
            cnt   <= '0;
            state <= CAPT;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        CAPT: begin
          res_angle <= cordic_angle;
          state     <= RESP;
        end
        RESP: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: table-driven and scoreboard bench for cordic_sched
// with a behavioural CORDIC that only settles after NITER enables.
module tb_cordic_sched;

  localparam int NREQ  = 4;
  localparam int NITER = 16;
  localparam int XW    = 129;

  logic              clock = 1'b0;
  logic              reset;
  logic              flush;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*XW-1:0] req_x;
  logic [NREQ*XW-1:0] req_y;
  logic [NREQ-1:0]   req_ready;
  logic              cordic_enable;
  logic              cordic_start;
  logic [XW-1:0]     cordic_x;
  logic [XW-1:0]     cordic_y;
  logic [18:0]       cordic_angle;
  logic              res_valid;
  logic              res_ready;
  logic [18:0]       res_angle;
  logic [2:0]        res_id;
  logic              busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int id;
    int ang;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [3:0] valid;
    longint     gx;
    longint     gy;
    int         exp_id;
    int         exp_ang;
  } vec_t;
  vec_t tab[8];

  cordic_sched #(.NREQ(NREQ), .NITER(NITER), .XW(XW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .cordic_enable(cordic_enable),
    .cordic_start(cordic_start), .cordic_x(cordic_x),
    .cordic_y(cordic_y), .cordic_angle(cordic_angle),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_angle(res_angle), .res_id(res_id), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [18:0] ang(longint x, longint y);
    real r;
    r = $atan2(real'(y), real'(x)) * 180.0 / 3.14159265358979 * 1024.0;
    return 19'($rtoi(r >= 0.0 ? r + 0.5 : r - 0.5));
  endfunction

  // CORDIC stand-in: angle is valid only after exactly NITER enables.
  int          mcnt = 99;
  logic [18:0] mang = '0;
  always @(posedge clock) begin
    if (cordic_start) begin
      mcnt <= 0;
      mang <= ang($signed(cordic_x[63:0]), $signed(cordic_y[63:0]));
    end else if (cordic_enable) begin
      mcnt <= mcnt + 1;
    end
  end
  assign cordic_angle = (mcnt == NITER) ? mang : 19'h2AAAA;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic samp();
    @(negedge clock);
  endtask

  task automatic chk(input string nm, input longint act,
                     input longint exp, input longint tol = 0);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_op(input int i, input longint x, input longint y);
    req_x[i*XW +: XW] = XW'(x);
    req_y[i*XW +: XW] = XW'(y);
  endtask

  task automatic decoys();
    for (int i = 0; i < NREQ; i++) set_op(i, -7, 537 + 37 * i);
  endtask

  task automatic garbage();
    for (int i = 0; i < NREQ; i++)
      set_op(i, longint'($urandom) - 70000, longint'($urandom));
  endtask

  // Called one cycle after acceptance; returns the res_valid latency.
  task automatic wait_res(output int lat, output bit bad);
    int l;
    bad = 1'b0;
    for (l = 1; l <= 40; l++) begin
      samp();
      if (res_valid) break;
      if (cordic_start != (l == 1) || cordic_enable != (l <= NITER + 1) ||
          req_ready != '0 || !busy)
        bad = 1'b1;
      step();
    end
    lat = l;
  endtask

  task automatic pop_cmp(input string nm);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({nm, "_queue"}, 0, 1);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_id"}, longint'(res_id), e.id);
      chk({nm, "_angle"}, longint'($signed(res_angle)), e.ang, 2);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int  lat;
    bit  bad;
    int  n;
    int  last;
    logic [18:0] ha;
    logic [2:0]  hid;

    tab[0] = '{4'b0001, 1000, 1000, 0, 46080};
    tab[1] = '{4'b0001, -1000, 0, 0, 184320};
    tab[2] = '{4'b1111, 0, 1000, 1, 92160};
    tab[3] = '{4'b0011, 1000, 0, 0, 0};
    tab[4] = '{4'b1000, 1000, -1000, 3, -46080};
    tab[5] = '{4'b0110, -1000, -1000, 1, -138240};
    tab[6] = '{4'b0100, 3, 4, 2, 54405};
    tab[7] = '{4'b1001, 123456789, -5, 3, 0};

    reset     = 1'b0;
    flush     = 1'b0;
    res_ready = 1'b0;
    req_valid = 4'b1111;
    decoys();

    // Reset state with all requests pending.
    repeat (2) step();
    samp();
    chk("rst_req_ready", longint'(req_ready), 0);
    chk("rst_ctrl", {busy, res_valid, cordic_enable, cordic_start}, 0);
    chk("rst_regs", (cordic_x == '0 && cordic_y == '0 &&
                     res_angle == '0 && res_id == '0), 1);
    req_valid = '0;
    reset     = 1'b1;

    // Table: grant order, latency, enable profile, result.
    for (int v = 0; v < 8; v++) begin
      step();
      decoys();
      set_op(tab[v].exp_id, tab[v].gx, tab[v].gy);
      req_valid = tab[v].valid;
      samp();
      chk($sformatf("v%0d_grant", v), longint'(req_ready),
          longint'(1 << tab[v].exp_id));
      sbq.push_back('{tab[v].exp_id, tab[v].exp_ang});
      step();
      req_valid = '0;
      garbage();
      wait_res(lat, bad);
      chk($sformatf("v%0d_latency", v), lat, NITER + 3);
      chk($sformatf("v%0d_profile", v), bad, 0);
      pop_cmp($sformatf("v%0d", v));
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      samp();
      chk($sformatf("v%0d_idle", v), {busy, res_valid}, 0);
    end

    // Contention: all four requesting, grants 0,1,2,3,0 every 20 cycles.
    sbq.delete();
    step();
    decoys();
    req_valid = 4'b1111;
    res_ready = 1'b1;
    n    = 0;
    last = 0;
    for (int c = 0; c < 130 && !(n == 5 && sbq.size() == 0); c++) begin
      samp();
      if (req_ready != '0) begin
        chk("cont_grant", longint'(req_ready), longint'(1 << (n % 4)));
        if (n > 0) chk("cont_spacing", c - last, 20);
        last = c;
        sbq.push_back('{n % 4, 0});
        n++;
      end
      if (res_valid) begin
        if (sbq.size() == 0) chk("cont_spurious", 1, 0);
        else chk("cont_id", longint'(res_id), sbq.pop_front().id);
      end
      step();
      if (n == 5) req_valid = '0;
    end
    chk("cont_count", n, 5);
    res_ready = 1'b0;
    sbq.delete();

    // Back-pressure: result held while res_ready is low.
    step();
    decoys();
    set_op(1, 0, 1000);
    req_valid = 4'b0010;
    samp();
    chk("bp_grant", longint'(req_ready), 2);
    step();
    req_valid = 4'b0100;
    wait_res(lat, bad);
    chk("bp_latency", lat, NITER + 3);
    ha  = res_angle;
    hid = res_id;
    chk("bp_id", longint'(hid), 1);
    chk("bp_angle", longint'($signed(ha)), 92160, 2);
    for (int k = 0; k < 10; k++) begin
      step();
      samp();
      chk("bp_hold", (res_valid && busy && res_id == hid &&
                      res_angle == ha && req_ready == '0), 1);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    samp();
    chk("bp_idle", busy, 0);
    chk("bp_next_ready", longint'(req_ready), 4);
    req_valid = '0;

    // Reset asserted in the eighth ITER cycle.
    step();
    decoys();
    req_valid = 4'b0100;
    samp();
    chk("rm_grant", longint'(req_ready), 4);
    step();
    req_valid = '0;
    repeat (8) step();
    chk("rm_pre_iter", (cordic_enable && !cordic_start && busy), 1);
    #1 reset = 1'b0;
    #1;
    chk("rm_zero", (!busy && !res_valid && !cordic_enable && !cordic_start &&
                    req_ready == '0 && cordic_x == '0 && cordic_y == '0 &&
                    res_angle == '0 && res_id == '0), 1);
    samp();
    reset = 1'b1;
    bad   = 1'b0;
    repeat (30) begin
      step();
      samp();
      if (busy || res_valid) bad = 1'b1;
    end
    chk("rm_quiet", bad, 0);

    // Flush in CAPT, then flush blocking a grant in IDLE.
    step();
    decoys();
    set_op(1, 1000, 0);
    req_valid = 4'b0001;
    samp();
    chk("fl_grant0", longint'(req_ready), 1);
    step();
    req_valid = '0;
    repeat (17) step();
    flush = 1'b1;
    samp();
    chk("fl_in_capt", (!cordic_enable && busy && !res_valid), 1);
    step();
    flush = 1'b0;
    samp();
    chk("fl_idle", {busy, res_valid}, 0);
    flush     = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("fl_ready_zero", longint'(req_ready), 0);
    step();
    flush = 1'b0;
    samp();
    chk("fl_no_accept", busy, 0);
    chk("fl_rr", longint'(req_ready), 2);
    sbq.push_back('{1, 0});
    step();
    req_valid = '0;
    wait_res(lat, bad);
    chk("fl_latency", lat, NITER + 3);
    pop_cmp("fl_next");
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
